ram_256x16: RTL and testbench

- Main memory stage directly downstream of the memory address register.
- Takes the registered 8-bit address plus 16-bit bus data. Performs CPU reads/writes under control-sequencer strobes.
- Includes a boot-load port that streams a program into memory with a valid/ready handshake before the CPU runs.
- ram_out feeds the bus tri-state/mux owned by the top level.

---
 rtl/sap_pkg.sv | 15 +
 rtl/ram_256x16_if.sv | 30 +++
 rtl/ram_256x16_core.sv | 35 +++
 rtl/ram_256x16.sv | 98 +++++++++
 tb/tb_ram_256x16.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP datapath: bus/address widths and the
// boot-loader state type used by the main memory stage.
package sap_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/ram_256x16_if.sv
// CPU-side and boot-loader-side signals of the main memory stage.
// The master side drives strobes and loader words; the slave side is the RAM.
interface ram_256x16_if;
  import sap_pkg::*;

  logic [ADDR_W-1:0] mar_addr;
  logic [DATA_W-1:0] bus;
  logic              ram_write;
  logic              ram_read;
  logic [DATA_W-1:0] ram_out;
  logic              prog_mode;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              prog_done;
  logic [ADDR_W:0]   prog_count;

  modport master (
    output mar_addr, bus, ram_write, ram_read,
    output prog_mode, prog_valid, prog_data,
    input  ram_out, prog_ready, prog_done, prog_count
  );

  modport slave (
    input  mar_addr, bus, ram_write, ram_read,
    input  prog_mode, prog_valid, prog_data,
    output ram_out, prog_ready, prog_done, prog_count
  );

endinterface

// File: rtl/ram_256x16_core.sv
// Single-port synchronous RAM with registered read data.
// A read and a write to the same word in one cycle return the old word.
module ram_core #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents survive reset so a loaded program is not lost.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_256x16.sv
// Main memory stage: CPU read/write port plus a valid/ready boot loader
// that streams a program into the array before the CPU runs.
module ram_256x16
  import sap_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ram_256x16_if.slave  io
);

  load_state_t       state;
  load_state_t       next_state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              ready_q;
  logic              done_q;
  logic              accept;

  logic              core_we;
  logic              core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  assign accept = (state == LOAD) && io.prog_valid;

  // Handshake flags are registered from the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      count   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == LOAD);
      done_q  <= (next_state == DONE);
      if ((state == IDLE) && io.prog_mode) begin
        ptr   <= '0;
        count <= '0;
      end else if (accept) begin
        ptr   <= ptr + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (io.prog_mode) next_state = LOAD;
      LOAD: if ((accept && (&ptr)) || !io.prog_mode) next_state = DONE;
      DONE: if (!io.prog_mode) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The loader owns the array while loading; CPU strobes only act in IDLE.
  always_comb begin
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_addr  = io.mar_addr;
    core_wdata = io.bus;
    unique case (state)
      IDLE: begin
        core_we = io.ram_write & ~rst;
        core_re = io.ram_read;
      end
      LOAD: begin
        core_we    = accept & ~rst;
        core_addr  = ptr;
        core_wdata = io.prog_data;
      end
      default: begin
      end
    endcase
  end

  ram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (core_we),
    .addr  (core_addr),
    .wdata (core_wdata),
    .re    (core_re),
    .rdata (core_rdata)
  );

  assign io.ram_out    = core_rdata;
  assign io.prog_ready = ready_q;
  assign io.prog_done  = done_q;
  assign io.prog_count = count;

endmodule

// File: tb/tb_ram_256x16.sv
// Randomized bench for ram_256x16 against a word-array reference model,
// with directed sequences for the CPU port, full/early loads and reset.
module tb_ram_256x16;
  import sap_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_256x16_if bus_if ();

  ram_256x16 dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if)
  );

  int total = 0;
  int bad   = 0;

  int ref_mem   [DEPTH];
  bit ref_known [DEPTH];
  int ref_out;
  bit ref_out_known = 1'b0;
  bit ref_loading   = 1'b0;
  bit ref_finished  = 1'b0;
  int ref_ptr       = 0;
  int ref_count     = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what one rising edge does to memory and the loader, given current inputs.
  task automatic refStep();
    int a;
    a = int'(bus_if.mar_addr);
    if (rst) begin
      ref_out       = 0;
      ref_out_known = 1'b1;
      ref_loading   = 1'b0;
      ref_finished  = 1'b0;
      ref_ptr       = 0;
      ref_count     = 0;
    end else if (ref_loading) begin
      if (bus_if.prog_valid) begin
        ref_mem[ref_ptr]   = int'(bus_if.prog_data);
        ref_known[ref_ptr] = 1'b1;
        ref_ptr            = (ref_ptr + 1) % DEPTH;
        ref_count++;
      end
      if (ref_count == DEPTH || !bus_if.prog_mode) begin
        ref_loading  = 1'b0;
        ref_finished = 1'b1;
      end
    end else if (ref_finished) begin
      if (!bus_if.prog_mode) ref_finished = 1'b0;
    end else begin
      if (bus_if.ram_read) begin
        ref_out       = ref_mem[a];
        ref_out_known = ref_known[a];
      end
      if (bus_if.ram_write) begin
        ref_mem[a]   = int'(bus_if.bus);
        ref_known[a] = 1'b1;
      end
      if (bus_if.prog_mode) begin
        ref_loading = 1'b1;
        ref_ptr     = 0;
        ref_count   = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit wr, input bit rd, input int addr,
                               input int dat, input bit pm, input bit pv, input int pd);
    rst               = r;
    bus_if.ram_write  = wr;
    bus_if.ram_read   = rd;
    bus_if.mar_addr   = ADDR_W'(addr);
    bus_if.bus        = DATA_W'(dat);
    bus_if.prog_mode  = pm;
    bus_if.prog_valid = pv;
    bus_if.prog_data  = DATA_W'(pd);
    refStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput("prog_ready", 32'(bus_if.prog_ready), 32'(ref_loading));
    checkOutput("prog_done", 32'(bus_if.prog_done), 32'(ref_finished));
    checkOutput("prog_count", 32'(bus_if.prog_count), 32'(ref_count));
    if (ref_out_known) checkOutput("ram_out", 32'(bus_if.ram_out), 32'(ref_out));
  endtask

  initial begin
    int words;
    bit pm;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = 0;
      ref_known[i] = 1'b0;
    end
    rst               = 1'b1;
    bus_if.ram_write  = 1'b0;
    bus_if.ram_read   = 1'b0;
    bus_if.mar_addr   = '0;
    bus_if.bus        = '0;
    bus_if.prog_mode  = 1'b0;
    bus_if.prog_valid = 1'b0;
    bus_if.prog_data  = '0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_ram_out", 32'(bus_if.ram_out), 32'h0);
    checkOutput("reset_ready", 32'(bus_if.prog_ready), 32'h0);
    checkOutput("reset_count", 32'(bus_if.prog_count), 32'h0);

    // CPU write then read
    applyStimulus(0, 1, 0, 'h10, 'hBEEF, 0, 0, 0);
    checkOutput("pre_read_out", 32'(bus_if.ram_out), 32'h0);
    applyStimulus(0, 0, 1, 'h10, 0, 0, 0, 0);
    checkOutput("beef_read", 32'(bus_if.ram_out), 32'hBEEF);

    // Same-cycle read and write returns the old word
    applyStimulus(0, 1, 0, 'h20, 'h1111, 0, 0, 0);
    applyStimulus(0, 1, 1, 'h20, 'h2222, 0, 0, 0);
    checkOutput("rbw_old", 32'(bus_if.ram_out), 32'h1111);
    applyStimulus(0, 0, 1, 'h20, 0, 0, 0, 0);
    checkOutput("rbw_new", 32'(bus_if.ram_out), 32'h2222);

    // Full 256-word boot load, value = index
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, i);
    checkOutput("full_done", 32'(bus_if.prog_done), 32'h1);
    checkOutput("full_count", 32'(bus_if.prog_count), 32'd256);
    checkOutput("full_ready", 32'(bus_if.prog_ready), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 'hAAAA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_idle", 32'(bus_if.prog_done), 32'h0);
    applyStimulus(0, 0, 1, 'h00, 0, 0, 0, 0);
    checkOutput("full_word0", 32'(bus_if.ram_out), 32'h0000);
    applyStimulus(0, 0, 1, 'hFF, 0, 0, 0, 0);
    checkOutput("full_wordFF", 32'(bus_if.ram_out), 32'h00FF);

    // Early termination with bubbles; CPU strobes must be ignored while loading
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    words = 0;
    for (int k = 0; k < 40 && words < 5; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        applyStimulus(0, 1, 1, 'h00, 'hDEAD, 1, 0, 'h9999);
      end else begin
        applyStimulus(0, 1, 1, 'h00, 'hDEAD, 1, 1, 'h3000 + words);
        words++;
      end
      checkOutput("isolation_out", 32'(bus_if.ram_out), 32'h00FF);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 'h3005);
    checkOutput("early_done", 32'(bus_if.prog_done), 32'h1);
    checkOutput("early_count", 32'(bus_if.prog_count), 32'd6);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("early_done_pulse", 32'(bus_if.prog_done), 32'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, i, 0, 0, 0, 0);
      checkOutput("early_word", 32'(bus_if.ram_out), 32'h3000 + 32'(i));
    end

    // Reset in the middle of a load
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 'h7000 + i);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("midrst_ready", 32'(bus_if.prog_ready), 32'h0);
    checkOutput("midrst_count", 32'(bus_if.prog_count), 32'h0);
    checkOutput("midrst_done", 32'(bus_if.prog_done), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, i, 0, 0, 0, 0);
      checkOutput("midrst_word", 32'(bus_if.ram_out), 32'h7000 + 32'(i));
    end

    // Random traffic mixing CPU accesses, loads and occasional resets
    pm = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) pm = ~pm;
      applyStimulus(($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15),
                    $urandom_range(0, 65535), pm,
                    1'($urandom_range(0, 1)), $urandom_range(0, 65535));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
